buffer_ctrl: RTL and testbench

Pointer, flag and write-arbitration controller for the MAC circular buffer of depth 2^BufferWidth. Two producers share the buffer's single write port under round-robin arbitration; one consumer pops. The block owns the write and read addresses and the wrap (Round) bit, and derives Full, Empty and Count from them. The storage array is external and is driven by W_En/W_Addr and R_En/R_Addr.

---
 rtl/buffer_ctrl.sv | 129 ++++++++++++
 tb/tb_buffer_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: pointer, flag and write-arbitration controller for a circular
// buffer of depth 2**BufferWidth. Two producers share the single write port
// under round-robin arbitration; one consumer pops. Storage lives outside.
module buffer_ctrl #(
  parameter int BufferWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             Push_Req,
  input  logic                   Pop,
  input  logic                   Clr_Err,
  output logic [1:0]             Grant,
  output logic                   W_En,
  output logic [BufferWidth-1:0] W_Addr,
  output logic                   R_En,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam logic [BufferWidth-1:0] PTR_ONE = {{(BufferWidth-1){1'b0}}, 1'b1};
  localparam logic [BufferWidth-1:0] PTR_MAX = {BufferWidth{1'b1}};

  logic [BufferWidth-1:0] r_waddr;
  logic [BufferWidth-1:0] r_raddr;
  logic                   r_round;
  logic                   r_last;     // index of the producer granted most recently
  logic                   r_ovf;
  logic                   r_udf;

  logic                   w_ptr_eq;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ren;
  logic                   w_push_ok;
  logic [1:0]             w_grant;
  logic                   w_wen;
  logic                   w_wwrap;
  logic                   w_rwrap;
  logic                   w_ovf_set;
  logic                   w_udf_set;
  logic [BufferWidth:0]   w_count;

  // Flags decode straight from the registered pointers and wrap bit.
  assign w_ptr_eq = (r_waddr == r_raddr);
  assign w_full   = r_round & w_ptr_eq;
  assign w_empty  = ~r_round & w_ptr_eq;

  // Strobes are forced low while reset is held so storage is never touched.
  assign w_ren     = rst & Pop & ~w_empty;
  // A pop accepted at Full frees the slot the push is about to use.
  assign w_push_ok = rst & (|Push_Req) & (~w_full | w_ren);

  // Round-robin grant: a lone requester wins, a tie goes to the other producer.
  always_comb begin
    w_grant = 2'b00;
    if (w_push_ok) begin
      case (Push_Req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_wen     = |w_grant;
  assign w_wwrap   = w_wen & (r_waddr == PTR_MAX);
  assign w_rwrap   = w_ren & (r_raddr == PTR_MAX);
  assign w_ovf_set = (|Push_Req) & ~w_wen;
  assign w_udf_set = Pop & w_empty;

  // Occupancy at BufferWidth+1 bits; the wrap bit contributes a full depth.
  assign w_count = {1'b0, r_waddr} - {1'b0, r_raddr} + {r_round, {BufferWidth{1'b0}}};

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_waddr <= '0;
    else if (w_wen) r_waddr <= r_waddr + PTR_ONE;
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_raddr <= '0;
    else if (w_ren) r_raddr <= r_raddr + PTR_ONE;
  end

  // Wrap bit flips on each pointer wrap; simultaneous wraps cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_round <= 1'b0;
    else      r_round <= r_round ^ w_wwrap ^ w_rwrap;
  end

  // Last-grant pointer moves only on an accepted push; reset favours producer 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_last <= 1'b1;
    else if (w_wen) r_last <= w_grant[1];
  end

  // Sticky error flags; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (Clr_Err) r_ovf <= 1'b0;
      if (w_udf_set)    r_udf <= 1'b1;
      else if (Clr_Err) r_udf <= 1'b0;
    end
  end

  assign Grant     = w_grant;
  assign W_En      = w_wen;
  assign W_Addr    = r_waddr;
  assign R_En      = w_ren;
  assign R_Addr    = r_raddr;
  assign Round     = r_round;
  assign Full      = w_full;
  assign Empty     = w_empty;
  assign Count     = w_count;
  assign Overflow  = r_ovf;
  assign Underflow = r_udf;

endmodule

// File: tb/tb_buffer_ctrl.sv
// tb_buffer_ctrl: scoreboard bench for buffer_ctrl (BufferWidth = 4).
module tb_buffer_ctrl;

  localparam int BW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    Push_Req = 2'b00;
  logic          Pop = 1'b0;
  logic          Clr_Err = 1'b0;
  logic [1:0]    Grant;
  logic          W_En;
  logic [BW-1:0] W_Addr;
  logic          R_En;
  logic [BW-1:0] R_Addr;
  logic          Round;
  logic          Full;
  logic          Empty;
  logic [BW:0]   Count;
  logic          Overflow;
  logic          Underflow;

  buffer_ctrl #(.BufferWidth(BW)) dut (
    .clk(clk), .rst(rst), .Push_Req(Push_Req), .Pop(Pop), .Clr_Err(Clr_Err),
    .Grant(Grant), .W_En(W_En), .W_Addr(W_Addr), .R_En(R_En), .R_Addr(R_Addr),
    .Round(Round), .Full(Full), .Empty(Empty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] wa;
    logic [BW-1:0] ra;
    logic          rnd;
    logic [BW:0]   cnt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: occupancy counter plus head/tail indices.
  int m_w, m_r, m_cnt, m_last;
  bit m_ovf, m_udf;

  logic [1:0] tb_gnt;
  logic       tb_ren;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_cnt = 0; m_last = 1; m_ovf = 0; m_udf = 0;
  endtask

  // One clock: drive, check strobes, queue expected state, compare after edge.
  task automatic step(input logic [1:0] preq, input logic pop, input logic clr);
    bit         m_full, m_empty, m_ren, m_ok;
    logic [1:0] m_gnt;
    exp_t       e;
    @(negedge clk);
    Push_Req = preq; Pop = pop; Clr_Err = clr;
    #1;
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    m_ren   = pop && !m_empty;
    m_ok    = (preq != 2'b00) && (!m_full || m_ren);
    if (!m_ok)              m_gnt = 2'b00;
    else if (preq == 2'b01) m_gnt = 2'b01;
    else if (preq == 2'b10) m_gnt = 2'b10;
    else                    m_gnt = (m_last == 0) ? 2'b10 : 2'b01;
    check_val("grant", {30'd0, Grant}, {30'd0, m_gnt});
    check_val("w_en", {31'd0, W_En}, {31'd0, (m_gnt != 2'b00)});
    check_val("r_en", {31'd0, R_En}, {31'd0, m_ren});
    tb_gnt = Grant;
    tb_ren = R_En;
    if (preq != 2'b00 && m_gnt == 2'b00) m_ovf = 1'b1;
    else if (clr)                        m_ovf = 1'b0;
    if (pop && m_empty) m_udf = 1'b1;
    else if (clr)       m_udf = 1'b0;
    if (m_gnt != 2'b00) begin
      m_w = (m_w + 1) % DEPTH; m_cnt++; m_last = m_gnt[1] ? 1 : 0;
    end
    if (m_ren) begin
      m_r = (m_r + 1) % DEPTH; m_cnt--;
    end
    e.wa    = m_w[BW-1:0];
    e.ra    = m_r[BW-1:0];
    e.rnd   = (m_r + m_cnt) >= DEPTH;
    e.cnt   = m_cnt[BW:0];
    e.full  = (m_cnt == DEPTH);
    e.empty = (m_cnt == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("w_addr", {28'd0, W_Addr}, {28'd0, e.wa});
    check_val("r_addr", {28'd0, R_Addr}, {28'd0, e.ra});
    check_val("round", {31'd0, Round}, {31'd0, e.rnd});
    check_val("count", {27'd0, Count}, {27'd0, e.cnt});
    check_val("full", {31'd0, Full}, {31'd0, e.full});
    check_val("empty", {31'd0, Empty}, {31'd0, e.empty});
    check_val("overflow", {31'd0, Overflow}, {31'd0, e.ovf});
    check_val("underflow", {31'd0, Underflow}, {31'd0, e.udf});
  endtask

  task automatic do_reset();
    @(negedge clk);
    Push_Req = 2'b00; Pop = 1'b0; Clr_Err = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset state, with requests applied while reset is held.
    #1 rst = 1'b0;
    Push_Req = 2'b01; Pop = 1'b1;
    #1;
    check_val("rst_grant", {30'd0, Grant}, 32'd0);
    check_val("rst_w_en", {31'd0, W_En}, 32'd0);
    check_val("rst_r_en", {31'd0, R_En}, 32'd0);
    check_val("rst_w_addr", {28'd0, W_Addr}, 32'd0);
    check_val("rst_r_addr", {28'd0, R_Addr}, 32'd0);
    check_val("rst_empty", {31'd0, Empty}, 32'd1);
    check_val("rst_full", {31'd0, Full}, 32'd0);
    check_val("rst_count", {27'd0, Count}, 32'd0);
    check_val("rst_flags", {30'd0, Overflow, Underflow}, 32'd0);
    @(negedge clk);
    Push_Req = 2'b00; Pop = 1'b0;
    rst = 1'b1;

    // Fill with producer 0, then one push too many.
    for (int i = 0; i < DEPTH; i++) step(2'b01, 1'b0, 1'b0);
    check_val("fill_count", {27'd0, Count}, 32'd16);
    check_val("fill_full", {31'd0, Full}, 32'd1);
    check_val("fill_round", {31'd0, Round}, 32'd1);
    check_val("fill_w_addr", {28'd0, W_Addr}, 32'd0);
    step(2'b01, 1'b0, 1'b0);
    check_val("ovf_grant", {30'd0, tb_gnt}, 32'd0);
    check_val("ovf_flag", {31'd0, Overflow}, 32'd1);

    // Full bypass: producer 1 pushes while the consumer pops.
    step(2'b10, 1'b1, 1'b0);
    check_val("byp_grant", {30'd0, tb_gnt}, 32'd2);
    check_val("byp_r_en", {31'd0, tb_ren}, 32'd1);
    check_val("byp_full", {31'd0, Full}, 32'd1);
    check_val("byp_count", {27'd0, Count}, 32'd16);
    check_val("byp_ptrs", {24'd0, W_Addr, R_Addr}, 32'h11);
    step(2'b00, 1'b0, 1'b1);
    check_val("ovf_clr", {31'd0, Overflow}, 32'd0);

    // Wrap and Round.
    do_reset();
    for (int i = 0; i < 3; i++)  step(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  step(2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(2'b01, 1'b0, 1'b0);
    check_val("wrap_w_addr", {28'd0, W_Addr}, 32'd1);
    check_val("wrap_r_addr", {28'd0, R_Addr}, 32'd3);
    check_val("wrap_round", {31'd0, Round}, 32'd1);
    check_val("wrap_count", {27'd0, Count}, 32'd14);
    for (int i = 0; i < 13; i++) step(2'b00, 1'b1, 1'b0);
    check_val("unwrap_r_addr", {28'd0, R_Addr}, 32'd0);
    check_val("unwrap_round", {31'd0, Round}, 32'd0);
    check_val("unwrap_count", {27'd0, Count}, 32'd1);

    // Round-robin with both producers, then producer 1 alone.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b0, 1'b0);
      check_val("rr_grant", {30'd0, tb_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    for (int i = 0; i < 2; i++) begin
      step(2'b10, 1'b0, 1'b0);
      check_val("solo_grant", {30'd0, tb_gnt}, 32'd2);
    end

    // Pop and push together on an empty buffer.
    do_reset();
    step(2'b01, 1'b1, 1'b0);
    check_val("emp_r_en", {31'd0, tb_ren}, 32'd0);
    check_val("emp_grant", {30'd0, tb_gnt}, 32'd1);
    check_val("emp_udf", {31'd0, Underflow}, 32'd1);
    check_val("emp_count", {27'd0, Count}, 32'd1);
    step(2'b00, 1'b0, 1'b1);
    check_val("udf_clr", {31'd0, Underflow}, 32'd0);
    // Set outranks clear in the same cycle.
    do_reset();
    step(2'b00, 1'b1, 1'b1);
    check_val("udf_set_wins", {31'd0, Underflow}, 32'd1);

    // Mixed random traffic, first mostly pushing, then mostly popping.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] rq;
      logic       pp, cl;
      rq = 2'($urandom_range(0, 3));
      pp = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 15) == 0);
      step(rq, pp, cl);
    end

    // Asynchronous reset between edges at Count = 7.
    do_reset();
    for (int i = 0; i < 7; i++) step(2'b01, 1'b0, 1'b0);
    check_val("pre_arst_count", {27'd0, Count}, 32'd7);
    #2 rst = 1'b0;
    #1;
    check_val("arst_w_addr", {28'd0, W_Addr}, 32'd0);
    check_val("arst_r_addr", {28'd0, R_Addr}, 32'd0);
    check_val("arst_round", {31'd0, Round}, 32'd0);
    check_val("arst_empty", {31'd0, Empty}, 32'd1);
    check_val("arst_grant", {30'd0, Grant}, 32'd0);
    model_reset();
    @(negedge clk);
    Push_Req = 2'b00;
    rst = 1'b1;
    step(2'b01, 1'b0, 1'b0);

    Push_Req = 2'b00; Pop = 1'b0; Clr_Err = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
